rs_232_out_fifo: RTL and testbench
==================================

RS_232_OUT_FIFO -- requirements
Module: rs_232_out_fifo

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 16, meaning clk cycles per serial bit (clk = 9600*16 Hz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte entries buffered ahead of the shifter.
REQ-003 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have wr_data, input, 8, byte to transmit.
REQ-006 SHALL have wr_en, input, 1, write strobe; wr_data is sampled on any edge where it is high.
REQ-007 SHALL have full, output, 1, high when level == FIFO_DEPTH.
REQ-008 SHALL have level, output, 3, FIFO occupancy, 0..FIFO_DEPTH.
REQ-009 SHALL have overflow, output, 1, one-cycle pulse when a write is dropped.
REQ-010 SHALL have shiftout, output, 1, registered serial line, idle high.
REQ-011 SHALL have busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have tx_done, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-013 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, no parity, 2 stop bits (1); each bit held exactly BIT_CYCLES cycles; frame length 11*BIT_CYCLES = 176 cycles.
REQ-014 States SHALL be IDLE, START, DATA and STOP, with a bit-cycle counter (0..BIT_CYCLES-1) and a bit index (0..7 in DATA, 0..1 in STOP).
REQ-015 IDLE: shiftout = 1; if level > 0, pop the head byte into the shift register, set shiftout to 0 and enter START on the same edge.
REQ-016 START -> DATA after BIT_CYCLES cycles; on entering DATA, shiftout = shift register bit 0.
REQ-017 DATA: every BIT_CYCLES cycles, shift the register right and drive the next bit; after bit 7 has been held BIT_CYCLES cycles, enter STOP with shiftout = 1.
REQ-018 STOP: hold shiftout = 1 for 2*BIT_CYCLES cycles, then pulse tx_done in the cycle in which the frame ends.
REQ-019 At the end of STOP with level > 0, the block SHALL pop and start the next frame on the same edge: back-to-back frames with no idle gap, 176-cycle period.
REQ-020 At the end of STOP with level == 0, the block SHALL return to IDLE.
REQ-021 Latency: a write accepted at edge E into an empty FIFO while IDLE SHALL produce the falling edge of shiftout at edge E+1.
REQ-022 A write SHALL be accepted when full = 0, or when full = 1 and a pop occurs on the same edge (level then stays at FIFO_DEPTH).
REQ-023 A write at full with no simultaneous pop SHALL be dropped, SHALL pulse overflow for one cycle, and SHALL leave FIFO contents unchanged.
REQ-024 A simultaneous write and pop at 0 < level < FIFO_DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-025 A write at level 0 while IDLE SHALL be popped on the following edge; the FIFO SHALL NOT bypass.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or underflow below 0.
REQ-027 wr_data SHALL be captured at write time; later changes to wr_data SHALL NOT alter queued bytes.

Reset
REQ-028 On any edge with rst = 1 the block SHALL enter IDLE and set shiftout = 1, busy = 0, tx_done = 0, overflow = 0, level = 0, full = 0, and clear both counters and both FIFO pointers.
REQ-029 Reset mid-frame SHALL abort the frame immediately (shiftout high from the next edge) and discard all queued bytes.
REQ-030 A wr_en asserted in a reset cycle SHALL be ignored.

Verification
REQ-031 Write 0xA5 once while IDLE -> starting one cycle later, shiftout = 0,1,0,1,0,0,1,0,1,1,1, each held 16 cycles; tx_done pulses at the end of cycle 176; busy falls to 0.
REQ-032 Write 0x00, 0xFF, 0x3C, 0x81 on consecutive cycles -> 4 contiguous 176-cycle frames with no idle gap; level goes 1,1,2,3 then decrements at each frame boundary; 4 tx_done pulses.
REQ-033 Write 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles -> 0x11 is popped on the second write's edge; bytes 0x11..0x55 are transmitted; the 0x66 write is dropped with level = 4, full = 1 and a single overflow pulse.
REQ-034 With FIFO full, write on the exact frame-end pop edge -> write accepted, level stays 4, no overflow pulse, byte transmitted in order.
REQ-035 Assert rst for 1 cycle at cycle 80 of a frame with 2 bytes queued -> next cycle shiftout = 1, level = 0, busy = 0; no tx_done; line stays high.
REQ-036 Write 0x5A at level 0 while IDLE, then hold wr_en low -> exactly one frame is sent, the line returns to idle high, and busy deasserts with tx_done.

Source files
------------

// File: rtl/rs_232_out_fifo.sv
// RS-232 transmitter with a small byte FIFO in front of the shifter.
//
// Frame: 1 start bit (0), 8 data bits LSB first, 2 stop bits (1), each bit
// held BIT_CYCLES clocks. Frames run back to back while the FIFO holds data.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous, active-high reset
//   wr_data   - byte to queue
//   wr_en     - write strobe, wr_data captured on every edge it is high
//   full      - FIFO holds FIFO_DEPTH bytes
//   level     - FIFO occupancy, 0..FIFO_DEPTH
//   overflow  - one-cycle pulse after a write was dropped
//   shiftout  - registered serial line, idle high
//   busy      - transmitter not idle
//   tx_done   - one-cycle pulse after each completed frame
module rs_232_out_fifo #(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic [2:0] level,
  output logic       overflow,
  output logic       shiftout,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(BIT_CYCLES - 1);
  localparam logic [2:0]      LevelMax = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            shiftout_q, shiftout_d;
  logic            tx_done_q, tx_done_d;
  logic            overflow_q, overflow_d;
  logic [2:0]      level_q, level_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic bit_end;
  logic have_data;
  logic pop;
  logic push;

  assign bit_end   = (cnt_q == CntLast);
  assign have_data = (level_q != 3'd0);

  // Transmit FSM: next state, counters, shift register and line level.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    shiftout_d = shiftout_q;
    tx_done_d  = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        shiftout_d = 1'b1;
        cnt_d      = '0;
        bit_idx_d  = '0;
        if (have_data) begin
          pop        = 1'b1;
          sh_d       = mem_q[rd_ptr_q];
          shiftout_d = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          shiftout_d = sh_q[0];
          state_d    = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d  = '0;
            shiftout_d = 1'b1;
            state_d    = StStop;
          end else begin
            // sh_q[1] becomes bit 0 after the shift: drive it now.
            sh_d       = {1'b0, sh_q[7:1]};
            shiftout_d = sh_q[1];
            bit_idx_d  = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd1) begin
            tx_done_d = 1'b1;
            bit_idx_d = '0;
            if (have_data) begin
              // Chain straight into the next start bit, no idle gap.
              pop        = 1'b1;
              sh_d       = mem_q[rd_ptr_q];
              shiftout_d = 1'b0;
              state_d    = StStart;
            end else begin
              shiftout_d = 1'b1;
              state_d    = StIdle;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        shiftout_d = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  // FIFO bookkeeping. A pop on the same edge frees the slot a full write needs;
  // the pop reads the old head before the write lands in that slot.
  always_comb begin
    push       = wr_en && ((level_q != LevelMax) || pop);
    overflow_d = wr_en && !push;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 3'd1;
    end else if (pop && !push) begin
      level_d = level_q - 3'd1;
    end

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      sh_q       <= '0;
      shiftout_q <= 1'b1;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      sh_q       <= sh_d;
      shiftout_q <= shiftout_d;
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = (level_q == LevelMax);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign shiftout = shiftout_q;
  assign busy     = (state_q != StIdle);
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_rs_232_out_fifo.sv
// Bench for rs_232_out_fifo: directed writes push expected bytes into a queue;
// a serial-line monitor decodes each frame and compares against the queue.
module tb_rs_232_out_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic [2:0] level;
  logic       overflow;
  logic       shiftout;
  logic       busy;
  logic       tx_done;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         rst_seen = 1'b0;
  logic [7:0] exp_q[$];

  rs_232_out_fifo #(
    .BIT_CYCLES(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .level   (level),
    .overflow(overflow),
    .shiftout(shiftout),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst) rst_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_tx);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_tx) exp_q.push_back(d);
  endtask

  // Garbage on wr_data after the strobe ends must not reach queued bytes.
  task automatic idle_in();
    wr_en   = 1'b0;
    wr_data = 8'hEE;
  endtask

  task automatic wait_tx(input int target, input int budget, input int t0, output int elapsed);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done) seen++;
      if (seen == target) break;
    end
    elapsed = cyc - t0;
    chk("tx_done_count", seen, target);
  endtask

  task automatic quiet_line(input int cycles, input string name);
    bit line_ok = 1'b1;
    bit no_done = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (shiftout !== 1'b1) line_ok = 1'b0;
      if (tx_done !== 1'b0) no_done = 1'b0;
    end
    chk({name, "_line_high"}, line_ok, 1'b1);
    chk({name, "_no_tx_done"}, no_done, 1'b1);
  endtask

  // Monitor: decode frames by sampling mid-bit, compare at frame end.
  initial begin
    logic [10:0] bits;
    logic [7:0]  e;
    bit          ab;
    @(negedge clk);
    forever begin
      if (rst === 1'b0 && shiftout === 1'b0) begin
        rst_seen = 1'b0;
        ab       = 1'b0;
        bits     = '0;
        for (int i = 0; i < 176; i++) begin
          if (i % 16 == 8) bits[i/16] = shiftout;
          @(negedge clk);
          if (rst_seen) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          chk("tx_done_at_frame_end", tx_done, 1'b1);
          chk("frame_start_stop", {bits[0], bits[9], bits[10]}, 3'b011);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %0h expected none", bits[8:1]);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", bits[8:1], e);
          end
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int el;

    // Reset with wr_en high: the write must be ignored.
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    repeat (3) @(negedge clk);
    chk("rst_shiftout", shiftout, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", level, 3'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    chk("post_rst_level", level, 3'd0);
    chk("post_rst_busy", busy, 1'b0);

    // Single byte 0xA5: latency and frame length.
    @(negedge clk);
    t0 = cyc;
    wr(8'hA5, 1'b1);
    @(negedge clk);
    chk("a5_level_after_write", level, 3'd1);
    chk("a5_line_still_idle", shiftout, 1'b1);
    idle_in();
    @(negedge clk);
    chk("a5_start_latency", shiftout, 1'b0);
    chk("a5_busy", busy, 1'b1);
    chk("a5_level_popped", level, 3'd0);
    wait_tx(1, 300, t0, el);
    chk("a5_frame_end_time", el, 178);
    chk("a5_busy_low", busy, 1'b0);

    // Four back-to-back frames.
    repeat (3) @(negedge clk);
    t0 = cyc;
    wr(8'h00, 1'b1);
    @(negedge clk);
    chk("b2b_level1", level, 3'd1);
    wr(8'hFF, 1'b1);
    @(negedge clk);
    chk("b2b_level2", level, 3'd1);
    wr(8'h3C, 1'b1);
    @(negedge clk);
    chk("b2b_level3", level, 3'd2);
    wr(8'h81, 1'b1);
    @(negedge clk);
    chk("b2b_level4", level, 3'd3);
    idle_in();
    wait_tx(4, 800, t0, el);
    chk("b2b_no_gap_end_time", el, 706);
    chk("b2b_busy_low", busy, 1'b0);

    // Overflow on the sixth consecutive write.
    repeat (3) @(negedge clk);
    t0 = cyc;
    wr(8'h11, 1'b1);
    @(negedge clk);
    chk("ovf_level1", level, 3'd1);
    wr(8'h22, 1'b1);
    @(negedge clk);
    chk("ovf_level2", level, 3'd1);
    wr(8'h33, 1'b1);
    @(negedge clk);
    chk("ovf_level3", level, 3'd2);
    wr(8'h44, 1'b1);
    @(negedge clk);
    chk("ovf_level4", level, 3'd3);
    wr(8'h55, 1'b1);
    @(negedge clk);
    chk("ovf_level5", level, 3'd4);
    chk("ovf_full", full, 1'b1);
    chk("ovf_no_pulse_yet", overflow, 1'b0);
    wr(8'h66, 1'b0);
    @(negedge clk);
    chk("ovf_level_held", level, 3'd4);
    chk("ovf_pulse", overflow, 1'b1);
    idle_in();
    @(negedge clk);
    chk("ovf_pulse_single", overflow, 1'b0);
    wait_tx(5, 1000, t0, el);
    chk("ovf_end_time", el, 882);

    // Write at full on the frame-end pop edge.
    repeat (3) @(negedge clk);
    t0 = cyc;
    wr(8'h01, 1'b1);
    @(negedge clk);
    wr(8'h02, 1'b1);
    @(negedge clk);
    wr(8'h03, 1'b1);
    @(negedge clk);
    wr(8'h04, 1'b1);
    @(negedge clk);
    wr(8'h05, 1'b1);
    @(negedge clk);
    idle_in();
    chk("popw_level_full", level, 3'd4);
    repeat (172) @(negedge clk);
    chk("popw_full_before", full, 1'b1);
    wr(8'h06, 1'b1);
    @(negedge clk);
    chk("popw_tx_done", tx_done, 1'b1);
    chk("popw_level", level, 3'd4);
    chk("popw_no_overflow", overflow, 1'b0);
    idle_in();
    @(negedge clk);
    chk("popw_no_overflow_next", overflow, 1'b0);
    wait_tx(5, 1000, t0, el);
    chk("popw_end_time", el, 1058);

    // Reset at cycle 80 of a frame with two bytes queued.
    repeat (3) @(negedge clk);
    wr(8'hC3, 1'b1);
    @(negedge clk);
    wr(8'h96, 1'b1);
    @(negedge clk);
    wr(8'hE1, 1'b1);
    @(negedge clk);
    idle_in();
    chk("abort_level_queued", level, 3'd2);
    repeat (79) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("abort_shiftout", shiftout, 1'b1);
    chk("abort_level", level, 3'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_full", full, 1'b0);
    quiet_line(400, "abort");

    // Single 0x5A, then idle.
    t0 = cyc;
    wr(8'h5A, 1'b1);
    @(negedge clk);
    idle_in();
    wait_tx(1, 300, t0, el);
    chk("5a_frame_end_time", el, 178);
    chk("5a_busy_low", busy, 1'b0);
    quiet_line(200, "5a_idle");

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
